fetch_stage: RTL and testbench

Instruction fetch stage: holds the PC, fetches one instruction at a time over a request/response handshake to instruction memory, and drives the IF/ID pipeline register that feeds the decode controller (`opcode`/`func`). It sits directly upstream of the controller. It accepts stall requests from the hazard unit and PC redirects from the jump path.

---
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem request/response handshake,
// one-entry skid buffer for stalled responses, and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [5:0]  ifid_opcode,
  output logic [5:0]  ifid_func
);

  typedef enum logic [1:0] {StFetch, StWait, StHold, StDrain} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] fetch_addr_q;
  logic [31:0] skid_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;
  logic        handshake;
  logic        unused_rpc_bits;

  // Request is masked during reset and while a redirect is being taken.
  assign imem_req  = rst_n && (state_q == StFetch) && !redirect;
  assign imem_addr = pc_q;
  assign handshake = imem_req && imem_ready;

  assign ifid_instr  = instr_q;
  assign ifid_pc4    = pc4_q;
  assign ifid_valid  = valid_q;
  assign ifid_opcode = instr_q[31:26];
  assign ifid_func   = instr_q[5:0];

  assign unused_rpc_bits = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      fetch_addr_q <= 32'h0;
      skid_q       <= 32'h0;
      instr_q      <= NOP_INSTR;
      pc4_q        <= 32'h0;
      valid_q      <= 1'b0;
    end else begin
      // Default when nothing is delivered: bubble unless stalled (pc4 always held).
      if (!stall) begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end

      if (redirect) begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
        pc_q    <= {redirect_pc[31:2], 2'b00};
        unique case (state_q)
          StFetch: state_q <= StFetch;
          StWait:  state_q <= imem_rvalid ? StFetch : StDrain;
          StHold:  state_q <= StFetch;
          StDrain: state_q <= StDrain;
          default: state_q <= StFetch;
        endcase
      end else begin
        unique case (state_q)
          StFetch: begin
            if (handshake) begin
              fetch_addr_q <= pc_q;
              pc_q         <= pc_q + 32'd4;
              state_q      <= StWait;
            end
          end
          StWait: begin
            if (imem_rvalid) begin
              if (!stall) begin
                instr_q <= imem_rdata;
                pc4_q   <= fetch_addr_q + 32'd4;
                valid_q <= 1'b1;
                state_q <= StFetch;
              end else begin
                skid_q  <= imem_rdata;
                state_q <= StHold;
              end
            end
          end
          StHold: begin
            if (!stall) begin
              instr_q <= skid_q;
              pc4_q   <= fetch_addr_q + 32'd4;
              valid_q <= 1'b1;
              state_q <= StFetch;
            end
          end
          StDrain: begin
            if (imem_rvalid) begin
              state_q <= StFetch;
            end
          end
          default: state_q <= StFetch;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// checked against a transaction-level model of the fetch stream.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0100;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] KEY       = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [5:0]  ifid_opcode;
  logic [5:0]  ifid_func;

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .ifid_valid  (ifid_valid),
    .ifid_opcode (ifid_opcode),
    .ifid_func   (ifid_func)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: one outstanding request, response after mem_cnt extra cycles.
  bit          mem_pending;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          mem_lat;
  bit          mem_rand;

  // Fetch-stream model: next fetch address, an outstanding request (possibly
  // cancelled by a redirect), and a fetched-but-not-yet-delivered instruction.
  logic [31:0] m_pc;
  bit          m_busy;
  logic [31:0] m_busy_addr;
  bit          m_drop;
  bit          m_held;
  logic [31:0] m_held_addr;
  logic [31:0] e_instr;
  logic [31:0] e_pc4;
  logic        e_valid;

  logic        obs_req;
  logic [31:0] obs_addr;
  logic        exp_req;
  logic [31:0] exp_addr;

  task automatic model_reset();
    m_pc = RESET_PC; m_busy = 0; m_drop = 0; m_held = 0;
    m_busy_addr = '0; m_held_addr = '0;
    e_instr = NOP_INSTR; e_pc4 = '0; e_valid = 1'b0;
    mem_pending = 0; mem_cnt = 0; mem_addr = '0;
  endtask

  task automatic quiet_inputs();
    stall = 0; redirect = 0; redirect_pc = '0; imem_ready = 0;
    imem_rvalid = 0; imem_rdata = '0;
  endtask

  // One clock cycle: drive inputs at the falling edge, capture the combinational
  // request, advance the models, then return 1ns after the rising edge.
  task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic rdy);
    bit          dlv;
    logic [31:0] d_addr;
    @(negedge clk);
    stall = st; redirect = rd; redirect_pc = rpc; imem_ready = rdy;
    if (mem_pending && mem_cnt == 0) begin
      imem_rvalid = 1'b1; imem_rdata = mem_addr ^ KEY;
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    #1;
    obs_req  = imem_req;
    obs_addr = imem_addr;
    exp_req  = !m_busy && !m_held && !rd;
    exp_addr = m_pc;

    dlv = 0; d_addr = '0;
    if (rd) begin
      if (m_busy && imem_rvalid) m_busy = 0;
      else if (m_busy) m_drop = 1;
      m_held  = 0;
      m_pc    = {rpc[31:2], 2'b00};
      e_instr = NOP_INSTR; e_valid = 1'b0;
    end else begin
      if (m_busy && imem_rvalid) begin
        m_busy = 0;
        if (m_drop) m_drop = 0;
        else if (st) begin m_held = 1; m_held_addr = m_busy_addr; end
        else begin dlv = 1; d_addr = m_busy_addr; end
      end else if (m_held && !st) begin
        dlv = 1; d_addr = m_held_addr; m_held = 0;
      end
      if (exp_req && rdy) begin
        m_busy = 1; m_busy_addr = m_pc; m_pc = m_pc + 32'd4;
      end
      if (dlv) begin
        e_instr = d_addr ^ KEY; e_pc4 = d_addr + 32'd4; e_valid = 1'b1;
      end else if (!st) begin
        e_instr = NOP_INSTR; e_valid = 1'b0;
      end
    end

    if (imem_rvalid) mem_pending = 0;
    else if (mem_pending && mem_cnt > 0) mem_cnt--;
    if (obs_req && rdy) begin
      mem_pending = 1; mem_addr = obs_addr;
      mem_cnt = mem_rand ? int'($urandom_range(0, 2)) : mem_lat;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    quiet_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    quiet_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_req: got %0b want 0", imem_req);
    end
    n_checks++;
    if (ifid_instr !== NOP_INSTR || ifid_pc4 !== 32'h0 || ifid_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ifid: got instr=%h pc4=%h v=%0b want %h/0/0",
               ifid_instr, ifid_pc4, ifid_valid, NOP_INSTR);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_first_req: got req=%0b addr=%h want 1/%h", imem_req, imem_addr,
               RESET_PC);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] addrs[$];
    logic [31:0] pc4s[$];
    logic [31:0] exp_seq[3];
    exp_seq = '{32'h100, 32'h104, 32'h108};
    do_reset();
    mem_rand = 0; mem_lat = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      if (obs_req) addrs.push_back(obs_addr);
      n_checks++;
      if (ifid_valid !== ((i % 2) == 1)) begin
        n_fail++; $display("FAIL seq_valid[%0d]: got %0b want %0b", i, ifid_valid, (i % 2) == 1);
      end
      if (ifid_valid) begin
        pc4s.push_back(ifid_pc4);
        n_checks++;
        if (ifid_instr !== ((ifid_pc4 - 32'd4) ^ KEY) || ifid_opcode !== ifid_instr[31:26]
            || ifid_func !== ifid_instr[5:0]) begin
          n_fail++;
          $display("FAIL seq_data[%0d]: got instr=%h op=%h fn=%h want instr=%h", i, ifid_instr,
                   ifid_opcode, ifid_func, (ifid_pc4 - 32'd4) ^ KEY);
        end
      end
    end
    n_checks++;
    if (addrs.size() < 3 || pc4s.size() < 3) begin
      n_fail++;
      $display("FAIL seq_count: got %0d reqs %0d instrs want 3/3", addrs.size(), pc4s.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (addrs[k] !== exp_seq[k] || pc4s[k] !== exp_seq[k] + 32'd4) begin
          n_fail++;
          $display("FAIL seq_addr[%0d]: got addr=%h pc4=%h want %h/%h", k, addrs[k], pc4s[k],
                   exp_seq[k], exp_seq[k] + 32'd4);
        end
      end
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    mem_rand = 0; mem_lat = 0;
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b1);
      n_checks++;
      if (obs_req !== 1'b0 || ifid_valid !== 1'b1 || ifid_pc4 !== 32'h104
          || ifid_instr !== (32'h100 ^ KEY)) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got req=%0b v=%0b pc4=%h instr=%h want 0/1/104/%h", i,
                 obs_req, ifid_valid, ifid_pc4, ifid_instr, 32'h100 ^ KEY);
      end
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if (obs_req !== 1'b0 || ifid_valid !== 1'b1 || ifid_pc4 !== 32'h108
        || ifid_instr !== (32'h104 ^ KEY)) begin
      n_fail++;
      $display("FAIL stall_release: got req=%0b v=%0b pc4=%h instr=%h want 0/1/108/%h",
               obs_req, ifid_valid, ifid_pc4, ifid_instr, 32'h104 ^ KEY);
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h108) begin
      n_fail++; $display("FAIL stall_next_req: got %0b/%h want 1/108", obs_req, obs_addr);
    end
  endtask

  task automatic test_redirect_drain();
    bit found;
    do_reset();
    mem_rand = 0; mem_lat = 2;
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b1, 32'h2003, 1'b1);
    n_checks++;
    if (ifid_valid !== 1'b0 || ifid_instr !== NOP_INSTR) begin
      n_fail++; $display("FAIL drain_bubble: got v=%0b instr=%h want 0/%h", ifid_valid,
                         ifid_instr, NOP_INSTR);
    end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      if (obs_req) begin
        found = 1;
        n_checks++;
        if (obs_addr !== 32'h2000) begin
          n_fail++; $display("FAIL drain_target: got %h want 00002000", obs_addr);
        end
      end else begin
        n_checks++;
        if (ifid_valid !== 1'b0) begin
          n_fail++; $display("FAIL drain_discard: got valid=%0b want 0", ifid_valid);
        end
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL drain_timeout: got no request want one within 10 cycles");
    end
  endtask

  task automatic test_redirect_in_hold();
    do_reset();
    mem_rand = 0; mem_lat = 0;
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b1, 32'h3000, 1'b1);
    n_checks++;
    if (obs_req !== 1'b0 || ifid_valid !== 1'b0 || ifid_instr !== NOP_INSTR) begin
      n_fail++; $display("FAIL hold_redirect: got req=%0b v=%0b instr=%h want 0/0/%h",
                         obs_req, ifid_valid, ifid_instr, NOP_INSTR);
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h3000) begin
      n_fail++; $display("FAIL hold_target: got %0b/%h want 1/3000", obs_req, obs_addr);
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h3004 || ifid_instr !== (32'h3000 ^ KEY)) begin
      n_fail++; $display("FAIL hold_target_data: got v=%0b pc4=%h instr=%h want 1/3004/%h",
                         ifid_valid, ifid_pc4, ifid_instr, 32'h3000 ^ KEY);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mem_rand = 0; mem_lat = 0;
    cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    n_checks++;
    if (obs_req !== 1'b0) begin
      n_fail++; $display("FAIL wrap_req_masked: got %0b want 0", obs_req);
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if (obs_req !== 1'b1 || obs_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_req: got %0b/%h want 1/fffffffc", obs_req, obs_addr);
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h0 || ifid_instr !== (32'hFFFF_FFFC ^ KEY)) begin
      n_fail++; $display("FAIL wrap_pc4: got v=%0b pc4=%h instr=%h want 1/0/%h", ifid_valid,
                         ifid_pc4, ifid_instr, 32'hFFFF_FFFC ^ KEY);
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_next: got %0b/%h want 1/0", obs_req, obs_addr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_rand = 0; mem_lat = 5;
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b0);
    mem_lat = 0;
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || ifid_valid !== 1'b0 || ifid_pc4 !== 32'h0
        || ifid_instr !== NOP_INSTR) begin
      n_fail++; $display("FAIL async_reset: got req=%0b v=%0b pc4=%h instr=%h want 0/0/0/%h",
                         imem_req, ifid_valid, ifid_pc4, ifid_instr, NOP_INSTR);
    end
    quiet_inputs();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
      n_fail++; $display("FAIL async_restart: got %0b/%h want 1/%h", obs_req, obs_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    logic        st;
    logic        rd;
    logic        rdy;
    logic [31:0] rpc;
    int          idle;
    do_reset();
    mem_rand = 1;
    idle = 0;
    for (int i = 0; i < 500; i++) begin
      st  = ($urandom % 4) == 0;
      rdy = ($urandom % 4) != 0;
      rd  = (($urandom % 10) == 0) && !(m_drop && mem_pending && mem_cnt == 0);
      rpc = (($urandom % 4) == 0) ? (32'hFFFF_FFF4 | ($urandom % 4)) : $urandom;
      cycle(st, rd, rpc, rdy);
      n_checks++;
      if (obs_req !== exp_req || (exp_req && obs_addr !== exp_addr)) begin
        n_fail++; $display("FAIL rand_req[%0d]: got %0b/%h want %0b/%h", i, obs_req, obs_addr,
                           exp_req, exp_addr);
      end
      n_checks++;
      if (ifid_valid !== e_valid || ifid_instr !== e_instr || ifid_pc4 !== e_pc4
          || ifid_opcode !== e_instr[31:26] || ifid_func !== e_instr[5:0]) begin
        n_fail++;
        $display("FAIL rand_ifid[%0d]: got v=%0b instr=%h pc4=%h op=%h fn=%h want %0b/%h/%h",
                 i, ifid_valid, ifid_instr, ifid_pc4, ifid_opcode, ifid_func, e_valid, e_instr,
                 e_pc4);
      end
      idle = e_valid ? 0 : idle + 1;
      if (idle > 200) begin
        n_checks++; n_fail++;
        $display("FAIL rand_progress: got %0d idle cycles want <= 200", idle);
        idle = 0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    quiet_inputs();
    mem_lat = 0; mem_rand = 0;
    model_reset();
    test_reset();
    test_sequential();
    test_stall_hold();
    test_redirect_drain();
    test_redirect_in_hold();
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
